// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults, width constants and the wrapped pointer increment for sync_fifo_v2.
package sync_fifo_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int PTR_W = $clog2(DEF_DEPTH);
    localparam int CNT_W = $clog2(DEF_DEPTH + 1);
    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        return (ptr == 32'(depth - 1)) ? '0 : ptr + 32'd1;
    endfunction
endpackage

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: arbitrary-depth show-ahead FIFO with count, watermarks and flush.
// Define SYNC_FIFO_ERR_EN to add sticky overflow_err/underflow_err outputs.
module sync_fifo_v2
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH    = DEF_WIDTH,
    parameter int FIFO_DEPTH    = DEF_DEPTH,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic                            push,
    input  logic [FIFO_WIDTH-1:0]           push_data,
    input  logic                            pop,
    output logic [FIFO_WIDTH-1:0]           pop_data,
    output logic                            fifo_full,
    output logic                            fifo_empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                            overflow_err,
    output logic                            underflow_err
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic pop_acc, push_acc;

    assign pop_acc  = pop && !fifo_empty;
    assign push_acc = push && (!fifo_full || pop_acc);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), FIFO_DEPTH));
            if (pop_acc) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), FIFO_DEPTH));
            count <= count + CW'(push_acc) - CW'(pop_acc);
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (push_acc && !i_rst && !i_flush) mem[wr_ptr] <= push_data;
    end

    assign fifo_count   = count;
    assign fifo_full    = 32'(count) == FIFO_DEPTH;
    assign fifo_empty   = count == '0;
    assign almost_full  = 32'(count) >= AFULL_THRESH;
    assign almost_empty = 32'(count) <= AEMPTY_THRESH;
    assign pop_data     = fifo_empty ? '0 : mem[rd_ptr];

`ifdef SYNC_FIFO_ERR_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) overflow_err <= 1'b1;
            if (pop && fifo_empty) underflow_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: queue-model scoreboard bench; directed checks on a 5-deep FIFO, random traffic on a 16-deep one.
module tb_sync_fifo_v2;
    import sync_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic fl0 = 1'b0, pu0 = 1'b0, po0 = 1'b0;
    logic [7:0] d0 = '0, pd0;
    logic full0, em0, af0, ae0;
    logic [2:0] c0;
    logic fl1 = 1'b0, pu1 = 1'b0, po1 = 1'b0;
    logic [7:0] d1 = '0, pd1;
    logic full1, em1, af1, ae1;
    logic [CNT_W-1:0] c1;
`ifdef SYNC_FIFO_ERR_EN
    logic ov0, un0, ov1, un1;
`endif

    sync_fifo_v2 #(.FIFO_WIDTH(8), .FIFO_DEPTH(5)) u0 (
        .i_clk(clk), .i_rst(rst), .i_flush(fl0), .push(pu0), .push_data(d0), .pop(po0),
        .pop_data(pd0), .fifo_full(full0), .fifo_empty(em0), .almost_full(af0),
        .almost_empty(ae0), .fifo_count(c0)
`ifdef SYNC_FIFO_ERR_EN
        , .overflow_err(ov0), .underflow_err(un0)
`endif
    );

    sync_fifo_v2 #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u1 (
        .i_clk(clk), .i_rst(rst), .i_flush(fl1), .push(pu1), .push_data(d1), .pop(po1),
        .pop_data(pd1), .fifo_full(full1), .fifo_empty(em1), .almost_full(af1),
        .almost_empty(ae1), .fifo_count(c1)
`ifdef SYNC_FIFO_ERR_EN
        , .overflow_err(ov1), .underflow_err(un1)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] m0[$], m1[$], e0[$], e1[$];
    bit mo0, mu0, mo1, mu1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: whenever a DUT hands out its head entry, compare with the scoreboard.
    always @(negedge clk) begin
        if (po0 && !em0 && !fl0 && !rst) begin
            if (e0.size() == 0) chk("sb0_unexpected_pop", 1, 0);
            else chk("sb0_pop_data", 32'(pd0), 32'(e0.pop_front()));
        end
    end
    always @(negedge clk) begin
        if (po1 && !em1 && !fl1 && !rst) begin
            if (e1.size() == 0) chk("sb1_unexpected_pop", 1, 0);
            else chk("sb1_pop_data", 32'(pd1), 32'(e1.pop_front()));
        end
    end

    task automatic status(input int s);
        int n, dep, aft;
        logic [7:0] head;
        dep = s ? 16 : 5;
        aft = s ? 14 : 3;
        n = s ? m1.size() : m0.size();
        head = n == 0 ? 8'h00 : (s ? m1[0] : m0[0]);
        chk(s ? "count1" : "count0", s ? 32'(c1) : 32'(c0), 32'(n));
        chk(s ? "full1" : "full0", s ? 32'(full1) : 32'(full0), 32'(n == dep));
        chk(s ? "empty1" : "empty0", s ? 32'(em1) : 32'(em0), 32'(n == 0));
        chk(s ? "afull1" : "afull0", s ? 32'(af1) : 32'(af0), 32'(n >= aft));
        chk(s ? "aempty1" : "aempty0", s ? 32'(ae1) : 32'(ae0), 32'(n <= 2));
        chk(s ? "head1" : "head0", s ? 32'(pd1) : 32'(pd0), 32'(head));
`ifdef SYNC_FIFO_ERR_EN
        chk(s ? "ovf1" : "ovf0", s ? 32'(ov1) : 32'(ov0), s ? 32'(mo1) : 32'(mo0));
        chk(s ? "unf1" : "unf0", s ? 32'(un1) : 32'(un0), s ? 32'(mu1) : 32'(mu0));
`endif
    endtask

    task automatic step(input int s, input bit pu, input bit po, input bit fl, input bit rs,
                        input logic [7:0] dat);
        int n, dep;
        bit pa, ua;
        dep = s ? 16 : 5;
        n = s ? m1.size() : m0.size();
        rst = rs;
        if (s == 0) begin pu0 = pu; po0 = po; fl0 = fl; d0 = dat; end
        else begin pu1 = pu; po1 = po; fl1 = fl; d1 = dat; end
        if (rs) begin
            m0.delete(); m1.delete();
            mo0 = 0; mu0 = 0; mo1 = 0; mu1 = 0;
        end else begin
            if (pu && n == dep && !po) begin if (s) mo1 = 1; else mo0 = 1; end
            if (po && n == 0) begin if (s) mu1 = 1; else mu0 = 1; end
            pa = po && n > 0;
            ua = pu && (n < dep || pa);
            if (fl) begin
                if (s) m1.delete(); else m0.delete();
            end else if (s == 0) begin
                if (pa) e0.push_back(m0.pop_front());
                if (ua) m0.push_back(dat);
            end else begin
                if (pa) e1.push_back(m1.pop_front());
                if (ua) m1.push_back(dat);
            end
        end
        @(posedge clk);
        #1;
        status(s);
    endtask

    initial begin
        int bias_pu, bias_po;
        #1;
        step(0, 0, 0, 0, 1, 8'h00);
        status(1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 8'hA0 + 8'(i));
        step(0, 1, 0, 0, 0, 8'hEE);
        step(0, 1, 1, 0, 0, 8'h55);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 8'h00);
        step(0, 1, 1, 0, 0, 8'h77);
        step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 8'h30 + 8'(i));
        step(0, 1, 0, 1, 0, 8'h99);
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        bias_pu = 50;
        bias_po = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 400 == 0) begin
                bias_pu = $urandom_range(10, 90);
                bias_po = $urandom_range(10, 90);
            end
            step(1, $urandom_range(0, 99) < bias_pu, $urandom_range(0, 99) < bias_po,
                 $urandom_range(0, 255) == 0, i == 5000, 8'($urandom));
        end
        step(1, 0, 0, 0, 0, 8'h00);
        chk("sb0_drained", 32'(e0.size()), 0);
        chk("sb1_drained", 32'(e1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_v2.md
Name: sync_fifo_v2

Overview:
- Parametrised synchronous FIFO; successor to the MMU-side request/response buffer.
- Adds arbitrary (non-power-of-two) depth, concurrent push and pop, occupancy count, programmable almost-full/almost-empty watermarks and a synchronous flush.
- Used between MMU page-walk request generation and the memory port, and for TLB refill response queues.

Parameters:
- FIFO_WIDTH, 32, data width in bits (>=1).
- FIFO_DEPTH, 16, number of entries (>=2; need not be a power of two).
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when count >= this value (1..FIFO_DEPTH).
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this value (0..FIFO_DEPTH-1).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_flush  in  1  synchronous discard of all entries.
- push  in  1  write request.
- push_data  in  FIFO_WIDTH  write data.
- pop  in  1  read request; pop_data is consumed on the cycle pop is accepted.
- pop_data  out  FIFO_WIDTH  head entry (show-ahead).
- fifo_full  out  1  count == FIFO_DEPTH.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.

Behaviour:
- Reset (i_rst high at a rising edge): rd_ptr = wr_ptr = 0, count = 0.
  - Outputs after reset: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0, fifo_count=0, pop_data=0.
  - Memory contents are not reset.
  - Reset overrides flush, push and pop.
- Priority order: i_rst > i_flush > push/pop.
  - Flush: pointers and count go to 0 at the next edge; any push or pop in the same cycle is ignored.
- Pointers: rd_ptr and wr_ptr are $clog2(FIFO_DEPTH) bits wide, each incremented on acceptance. At FIFO_DEPTH-1 a pointer wraps to 0 (explicit compare, not natural overflow).
- Occupancy: a count register holds occupancy; full and empty are decoded from count, not from pointers.
- Push accepted = push && (!fifo_full || pop_accepted).
  - When full, a simultaneous pop frees the slot, so the push is accepted in the same cycle.
- Pop accepted = pop && !fifo_empty.
  - When empty, a simultaneous push is accepted and the pop is ignored. There is no bypass from push_data to pop_data.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged when both are accepted.
  - Unchanged when neither is accepted.
- Latency:
  - Written data is visible on pop_data in the cycle after the push edge.
  - pop_data = mem[rd_ptr] combinationally when not empty; forced to 0 when empty.
- Status flags: all flags and fifo_count are combinational decodes of the count register, so they change only at clock edges.
- Dropped requests: a push rejected while full, or a pop rejected while empty, leaves state unchanged (no side effects).

Optional Feature:
- Macro SYNC_FIFO_ERR_EN.
- When defined, adds two outputs:
  - overflow_err (1 bit): sticky; set on the edge where push && fifo_full && !pop.
  - underflow_err (1 bit): sticky; set on the edge where pop && fifo_empty.
  - Both are cleared only by i_rst. i_flush does not clear them.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package sync_fifo_pkg holds:
  - helper function ptr_inc(ptr, depth), which returns the wrapped increment;
  - localparam PTR_W = $clog2(FIFO_DEPTH);
  - localparam CNT_W = $clog2(FIFO_DEPTH+1).
- No sub-module: storage is an inferred register array inside sync_fifo_v2. An instance of the package function is used for both pointers.

Test Plan:
- Reset, then 5 pushes (0xA0..0xA4) with no pop -> fifo_count=5; pop_data=0xA0 one cycle after first push; almost_empty=0 once count=3.
- FIFO_DEPTH=5: fill with 5 pushes -> fifo_full=1. Sixth push alone -> count stays 5 (overflow_err=1 if SYNC_FIFO_ERR_EN). Then 7 pops -> data returned in order, count reaches 0, wrap exercised.
- Full, then push 0x55 and pop in the same cycle -> head entry consumed, 0x55 stored, count stays FIFO_DEPTH, fifo_full stays 1.
- Empty, then push 0x77 and pop in the same cycle -> count=1 and pop_data=0x77 next cycle. Pop alone while empty -> no change (underflow_err=1 if enabled).
- Count=3, assert i_flush with push=1 -> next cycle count=0, fifo_empty=1, pushed word discarded. With SYNC_FIFO_ERR_EN, sticky flags survive the flush; i_rst clears them.
- Random push/pop for 10k cycles against a queue model, using DEPTH=16, AFULL_THRESH=14, AEMPTY_THRESH=2 -> data order and all flags match the model every cycle.
